// File: rtl/hall_speed_sequencer_pkg.sv
// hall_pkg: shared types and constants for the hall-sensor speed sequencer.
//   - hall_state_e     : sequencer state encoding (also exposed in the status word)
//   - ADDR_*           : Avalon-MM register addresses
//   - STAT_*           : bit positions inside the status register
//   - hall_next()      : forward successor of a hall code (000/111 map to 000)
//   - hall_legal()     : true for the six codes a healthy sensor set can produce
package hall_pkg;

    typedef enum logic [1:0] {
        ARM   = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } hall_state_e;

    localparam logic [1:0] ADDR_PERIOD  = 2'd0;
    localparam logic [1:0] ADDR_EDGES   = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_TIMEOUT = 2'd3;

    localparam int STAT_HALL_LSB  = 0;
    localparam int STAT_DIR_BIT   = 3;
    localparam int STAT_STALL_BIT = 4;
    localparam int STAT_ERR_BIT   = 5;
    localparam int STAT_STATE_LSB = 6;

    // Forward rotation: 001 -> 011 -> 010 -> 110 -> 100 -> 101 -> 001
    function automatic logic [2:0] hall_next(input logic [2:0] code);
        case (code)
            3'b001:  return 3'b011;
            3'b011:  return 3'b010;
            3'b010:  return 3'b110;
            3'b110:  return 3'b100;
            3'b100:  return 3'b101;
            3'b101:  return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic hall_legal(input logic [2:0] code);
        return (code != 3'b000) && (code != 3'b111);
    endfunction

endpackage

// File: rtl/hall_speed_sequencer_if.sv
// hall_speed_sequencer_if: Avalon-MM read-only slave bus.
//   avs_address       2  register select
//   avs_read          1  read strobe
//   avs_readdata      32 registered read data
//   avs_readdatavalid 1  qualifier, one cycle after avs_read
// master = HPS side, slave = sequencer side.
interface hall_speed_sequencer_if;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;

    modport master (output avs_address, avs_read, input avs_readdata, avs_readdatavalid);
    modport slave  (input avs_address, avs_read, output avs_readdata, avs_readdatavalid);
endinterface

// File: rtl/hall_speed_sequencer_input_filter.sv
// hall_input_filter: two-flop synchronizer for the three hall inputs, with an
// optional debounce stage.
//   clock, reset      system clock, async active-high reset
//   hall_raw[2:0]     raw sensors {h3,h2,h1}
//   hall_s[2:0]       filtered code
//   hall_s_valid      hall_s carries a real sampled code (not the reset value)
// Build option: HALL_DEBOUNCE_EN -- when defined, a synchronized code must stay
// unchanged for DEBOUNCE_CYCLES consecutive clocks before it reaches hall_s.
module hall_input_filter #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] hall_raw,
    output logic [2:0] hall_s,
    output logic       hall_s_valid
);
    localparam int SYNC_STAGES = 1;

    if (DEBOUNCE_CYCLES < 2) begin : g_cfg_check
        $error("hall_input_filter: DEBOUNCE_CYCLES must be at least 2");
    end

    logic [2:0]             sync1, sync2;
    // Marks when sync2 holds a sampled value rather than the reset zeros.
    logic [SYNC_STAGES:0]   vld_pipe;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            vld_pipe <= '0;
        end else begin
            sync1    <= hall_raw;
            sync2    <= sync1;
            vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
        end
    end

`ifdef HALL_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [2:0]    cand;
    logic [2:0]    hall_q;
    logic [CW-1:0] stable_cnt;
    logic          fwd_ok;

    // stable_cnt = number of cycles sync2 has equalled cand. Forwarding on the
    // edge where the count is DEBOUNCE_CYCLES-1 and still matching means the
    // code was seen for DEBOUNCE_CYCLES cycles; the count then parks.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cand       <= '0;
            hall_q     <= '0;
            stable_cnt <= '0;
            fwd_ok     <= 1'b0;
        end else if (vld_pipe[SYNC_STAGES]) begin
            if (sync2 != cand) begin
                cand       <= sync2;
                stable_cnt <= CW'(1);
            end else if (stable_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                hall_q     <= cand;
                fwd_ok     <= 1'b1;
                stable_cnt <= CW'(DEBOUNCE_CYCLES);
            end else if (stable_cnt < CW'(DEBOUNCE_CYCLES - 1)) begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

    assign hall_s       = hall_q;
    assign hall_s_valid = fwd_ok;
`else
    assign hall_s       = sync2;
    assign hall_s_valid = vld_pipe[SYNC_STAGES];
`endif

endmodule

// File: rtl/hall_speed_sequencer.sv
// hall_speed_sequencer: hall-sensor commutation sequencer and speed timer.
//   clock, reset                 system clock, async active-high reset
//   hall_sensor1..3              raw asynchronous hall inputs
//   avs (slave modport)          Avalon-MM read slave: 0 period, 1 edge_count,
//                                2 status, 3 TIMEOUT_TICKS
//   period / period_valid        last event interval in prescaled ticks + pulse
//   direction                    1 forward, 0 reverse
//   stalled                      no event for TIMEOUT_TICKS ticks
//   hall_error                   sticky illegal/skip flag, cleared by status read
// Build option: HALL_DEBOUNCE_EN enables the input debounce in hall_input_filter.
module hall_speed_sequencer
    import hall_pkg::*;
#(
    parameter int PRESCALE        = 500,
    parameter int TIMEOUT_TICKS   = 70000,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         hall_sensor1,
    input  logic                         hall_sensor2,
    input  logic                         hall_sensor3,
    hall_speed_sequencer_if.slave        avs,
    output logic [31:0]                  period,
    output logic                         period_valid,
    output logic                         direction,
    output logic                         stalled,
    output logic                         hall_error
);
    localparam int          PW          = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [31:0] TIMEOUT_VAL = 32'(TIMEOUT_TICKS);

    localparam logic [1:0] S_ARM   = ARM;
    localparam logic [1:0] S_RUN   = RUN;
    localparam logic [1:0] S_STALL = STALL;

    logic [2:0]    hall_s;
    logic          hall_s_valid;
    logic [2:0]    hall_prev;
    logic          prev_ok;
    logic [PW-1:0] presc;
    logic          tick;
    logic [31:0]   tick_cnt;
    logic [31:0]   edge_count;
    logic [1:0]    state;
    logic          hall_event, step_fwd, step_rev, valid_evt, err_evt;
    logic          status_rd;
    logic [31:0]   status_word;

    hall_input_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filter (
        .clock        (clock),
        .reset        (reset),
        .hall_raw     ({hall_sensor3, hall_sensor2, hall_sensor1}),
        .hall_s       (hall_s),
        .hall_s_valid (hall_s_valid)
    );

    // prev_ok keeps the first real code after reset from being compared
    // against the zero reset value of hall_prev.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hall_prev <= '0;
            prev_ok   <= 1'b0;
        end else begin
            hall_prev <= hall_s;
            prev_ok   <= hall_s_valid;
        end
    end

    always_comb begin
        hall_event = hall_s_valid && prev_ok && (hall_s != hall_prev);
        step_fwd   = (hall_next(hall_prev) == hall_s);
        step_rev   = (hall_next(hall_s) == hall_prev);
        // Legality of both codes is required: hall_next(111) is 000, which
        // would otherwise make 000 -> 111 look like a reverse step.
        valid_evt  = hall_event && hall_legal(hall_prev) && hall_legal(hall_s)
                     && (step_fwd || step_rev);
        err_evt    = hall_event && !valid_evt;
        status_rd  = avs.avs_read && (avs.avs_address == ADDR_STATUS);
    end

    assign tick = (presc == PW'(PRESCALE - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) presc <= '0;
        else if (tick) presc <= '0;
        else presc <= presc + 1'b1;
    end

    // Interval counter: a valid event clears it even when a tick lands in the
    // same cycle; otherwise it counts ticks and parks at the timeout value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) tick_cnt <= '0;
        else if (valid_evt) tick_cnt <= '0;
        else if (tick && (tick_cnt != TIMEOUT_VAL)) tick_cnt <= tick_cnt + 32'd1;
    end

    // Priority: error event > valid event > timeout.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_ARM;
            period       <= '0;
            period_valid <= 1'b0;
            direction    <= 1'b0;
            stalled      <= 1'b0;
            hall_error   <= 1'b0;
            edge_count   <= '0;
        end else begin
            period_valid <= 1'b0;

            if (err_evt) hall_error <= 1'b1;
            else if (status_rd) hall_error <= 1'b0;

            if (valid_evt) begin
                edge_count <= edge_count + 32'd1;
                direction  <= step_fwd;
            end

            if (err_evt) begin
                state   <= S_ARM;
                stalled <= 1'b0;
            end else if (valid_evt) begin
                case (state)
                    S_RUN: begin
                        period       <= tick_cnt;
                        period_valid <= 1'b1;
                    end
                    S_STALL: stalled <= 1'b0;
                    default: ;
                endcase
                state <= S_RUN;
            end else if ((state == S_RUN) && (tick_cnt == TIMEOUT_VAL)) begin
                period  <= '0;
                stalled <= 1'b1;
                state   <= S_STALL;
            end
        end
    end

    always_comb begin
        status_word                          = '0;
        status_word[STAT_HALL_LSB +: 3]      = hall_s;
        status_word[STAT_DIR_BIT]            = direction;
        status_word[STAT_STALL_BIT]          = stalled;
        status_word[STAT_ERR_BIT]            = hall_error;
        status_word[STAT_STATE_LSB +: 2]     = state;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            avs.avs_readdata      <= '0;
            avs.avs_readdatavalid <= 1'b0;
        end else begin
            avs.avs_readdatavalid <= avs.avs_read;
            if (avs.avs_read) begin
                case (avs.avs_address)
                    ADDR_PERIOD: avs.avs_readdata <= period;
                    ADDR_EDGES:  avs.avs_readdata <= edge_count;
                    ADDR_STATUS: avs.avs_readdata <= status_word;
                    default:     avs.avs_readdata <= TIMEOUT_VAL;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hall_speed_sequencer.sv
// Self-checking bench for hall_speed_sequencer (PRESCALE=5, TIMEOUT_TICKS=100).
// Reference model works per event: tick counts between events are computed
// arithmetically from the cycle index, stall status is derived lazily from
// the time since the last clear. HALL_DEBOUNCE_EN adds the glitch scenario.
module tb_hall_speed_sequencer;
    localparam int PRE = 5;
    localparam int TO  = 100;
    localparam int DEB = 16;
`ifdef HALL_DEBOUNCE_EN
    localparam int LAT = 3 + DEB;
`else
    localparam int LAT = 3;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        hall_sensor1, hall_sensor2, hall_sensor3;
    logic [31:0] period;
    logic        period_valid, direction, stalled, hall_error;

    hall_speed_sequencer_if bus ();

    hall_speed_sequencer #(.PRESCALE(PRE), .TIMEOUT_TICKS(TO), .DEBOUNCE_CYCLES(DEB)) dut (
        .clock        (clock),
        .reset        (reset),
        .hall_sensor1 (hall_sensor1),
        .hall_sensor2 (hall_sensor2),
        .hall_sensor3 (hall_sensor3),
        .avs          (bus.slave),
        .period       (period),
        .period_valid (period_valid),
        .direction    (direction),
        .stalled      (stalled),
        .hall_error   (hall_error)
    );

    always #5 clock = ~clock;

    // cyc == number of rising edges since reset release (valid at negedge)
    int cyc;
    always @(posedge clock) begin
        if (reset) cyc <= 0;
        else cyc <= cyc + 1;
    end

    int vectors = 0;
    int miscompares = 0;

    // model state
    logic [2:0] seq [6];
    logic [2:0] m_code;
    int         m_mode;    // 0 waiting for first good event, 1 timing
    int         m_c;       // cycle of last counter clear
    int         m_edges;
    int         m_period;
    bit         m_dir, m_err;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic int upto(input int n);
        return (n < 0) ? 0 : (n + 1) / PRE;
    endfunction

    function automatic int ticks(input int a, input int b);
        if (b < a) return 0;
        return upto(b) - upto(a - 1);
    endfunction

    function automatic bit m_stalled(input int n);
        return (m_mode == 1) && (ticks(m_c + 1, n - 2) >= TO);
    endfunction

    function automatic int pos_of(input logic [2:0] c);
        for (int i = 0; i < 6; i++) if (seq[i] == c) return i;
        return -1;
    endfunction

    function automatic logic [31:0] exp_period(input int n);
        return m_stalled(n) ? 32'd0 : 32'(m_period);
    endfunction

    function automatic logic [31:0] exp_status(input int n);
        logic [31:0] s;
        s      = '0;
        s[2:0] = m_code;
        s[3]   = m_dir;
        s[4]   = m_stalled(n);
        s[5]   = m_err;
        s[7:6] = (m_mode == 0) ? 2'd0 : (m_stalled(n) ? 2'd2 : 2'd1);
        return s;
    endfunction

    function automatic logic [31:0] exp_reg(input logic [1:0] a, input int n);
        case (a)
            2'd0:    return exp_period(n);
            2'd1:    return 32'(m_edges);
            2'd2:    return exp_status(n);
            default: return 32'(TO);
        endcase
    endfunction

    // Drive a new sensor code at a negedge, check the capture LAT cycles
    // later, then idle so that gap clocks separate successive changes.
    task automatic apply(input logic [2:0] code, input int gap);
        int j, e, n, pa, pb;
        bit pulse, fwd;
        pulse = 0;
        {hall_sensor3, hall_sensor2, hall_sensor1} = code;
        j = cyc;
        e = j + LAT - 1;
        if (code != m_code) begin
            pa  = pos_of(m_code);
            pb  = pos_of(code);
            fwd = (pa >= 0) && (pb >= 0) && (pb == (pa + 1) % 6);
            if (fwd || ((pa >= 0) && (pb >= 0) && (pa == (pb + 1) % 6))) begin
                m_edges++;
                m_dir = fwd;
                if (m_mode == 0) begin
                    m_mode = 1;
                end else if (m_stalled(e)) begin
                    m_period = 0;
                end else begin
                    m_period = ticks(m_c + 1, e - 1);
                    if (m_period > TO) m_period = TO;
                    pulse = 1;
                end
                m_c = e;
            end else begin
                if (m_stalled(e)) m_period = 0;
                m_err  = 1;
                m_mode = 0;
            end
            m_code = code;
        end
        repeat (LAT) @(negedge clock);
        n = cyc;
        chk1("period_valid", period_valid, pulse);
        chk32("period", period, exp_period(n));
        chk1("direction", direction, m_dir);
        chk1("stalled", stalled, m_stalled(n));
        chk1("hall_error", hall_error, m_err);
        if (gap > LAT) repeat (gap - LAT) @(negedge clock);
    endtask

    task automatic do_read(input logic [1:0] a);
        logic [31:0] exp;
        bus.avs_address = a;
        bus.avs_read    = 1'b1;
        exp = exp_reg(a, cyc);
        @(negedge clock);
        bus.avs_read = 1'b0;
        if (a == 2'd2) m_err = 0;
        chk1("readdatavalid", bus.avs_readdatavalid, 1'b1);
        chk32($sformatf("readdata[%0d]", a), bus.avs_readdata, exp);
        @(negedge clock);
        chk1("readdatavalid_idle", bus.avs_readdatavalid, 1'b0);
        chk32("readdata_hold", bus.avs_readdata, exp);
    endtask

    initial begin
        logic [2:0]  nxt;
        logic [31:0] e1, e2;
        int p, r;

        seq[0] = 3'b001; seq[1] = 3'b011; seq[2] = 3'b010;
        seq[3] = 3'b110; seq[4] = 3'b100; seq[5] = 3'b101;
        m_code = 3'b001; m_mode = 0; m_c = 0; m_edges = 0; m_period = 0;
        m_dir = 0; m_err = 0;

        reset = 1'b1;
        {hall_sensor3, hall_sensor2, hall_sensor1} = 3'b001;
        bus.avs_address = 2'd0;
        bus.avs_read    = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (25) @(negedge clock);

        // 1: reset state
        chk32("rst_period", period, 32'd0);
        chk1("rst_period_valid", period_valid, 1'b0);
        chk1("rst_direction", direction, 1'b0);
        chk1("rst_stalled", stalled, 1'b0);
        chk1("rst_hall_error", hall_error, 1'b0);
        chk1("rst_readdatavalid", bus.avs_readdatavalid, 1'b0);
        chk32("rst_readdata", bus.avs_readdata, 32'd0);
        do_read(2'd2);
        do_read(2'd1);
        do_read(2'd3);

`ifdef HALL_DEBOUNCE_EN
        // 6: short glitch must not produce an event
        {hall_sensor3, hall_sensor2, hall_sensor1} = 3'b011;
        repeat (5) @(negedge clock);
        {hall_sensor3, hall_sensor2, hall_sensor1} = 3'b001;
        repeat (30) @(negedge clock);
        chk1("glitch_no_pulse", period_valid, 1'b0);
        do_read(2'd1);
        do_read(2'd2);
`endif

        // 2: forward, 7 events
        for (int i = 1; i <= 7; i++) apply(seq[i % 6], 250);
        do_read(2'd1);
        do_read(2'd0);

        // 3: reverse, then a short interval
        p = pos_of(m_code);
        for (int i = 1; i <= 6; i++) apply(seq[(p + 6 - (i % 6)) % 6], 250);
        p = pos_of(m_code);
        apply(seq[(p + 5) % 6], 600);

        // 4: stall after long idle, recovery
        chk1("stall_flag", stalled, 1'b1);
        chk32("stall_period", period, exp_period(cyc));
        do_read(2'd2);
        p = pos_of(m_code);
        apply(seq[(p + 1) % 6], 250);
        apply(seq[(p + 2) % 6], 250);

        // 5: skip error, back-to-back status reads
        p = pos_of(m_code);
        apply(seq[(p + 3) % 6], 40);
        bus.avs_address = 2'd2;
        bus.avs_read    = 1'b1;
        e1 = exp_status(cyc);
        @(negedge clock);
        m_err = 0;
        e2 = exp_status(cyc);
        chk1("b2b_valid1", bus.avs_readdatavalid, 1'b1);
        chk32("b2b_status1", bus.avs_readdata, e1);
        chk1("err_bit_set", bus.avs_readdata[5], 1'b1);
        @(negedge clock);
        bus.avs_read = 1'b0;
        chk1("b2b_valid2", bus.avs_readdatavalid, 1'b1);
        chk32("b2b_status2", bus.avs_readdata, e2);
        chk1("err_bit_clear", bus.avs_readdata[5], 1'b0);
        @(negedge clock);

        // randomized walk: steps, skips, illegal codes, random gaps and reads
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            p = pos_of(m_code);
            if (p < 0) nxt = seq[$urandom_range(0, 5)];
            else if (r < 5) nxt = seq[(p + 1) % 6];
            else if (r < 8) nxt = seq[(p + 5) % 6];
            else if (r == 8) nxt = seq[(p + 2 + $urandom_range(0, 2)) % 6];
            else nxt = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b111;
            apply(nxt, $urandom_range(LAT + 3, 450));
            if ($urandom_range(0, 1) == 1) do_read(2'($urandom_range(0, 3)));
        end
        do_read(2'd1);

        // reset mid-operation
        reset = 1'b1;
        @(negedge clock);
        chk32("midrst_period", period, 32'd0);
        chk1("midrst_direction", direction, 1'b0);
        chk1("midrst_stalled", stalled, 1'b0);
        chk1("midrst_hall_error", hall_error, 1'b0);
        chk1("midrst_readdatavalid", bus.avs_readdatavalid, 1'b0);
        chk32("midrst_readdata", bus.avs_readdata, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
